// File: rtl/umi_ingress_fifo2.sv
// ============================================================================
// umi_ingress_fifo2 : generic 2-entry synchronous FIFO, W-bit payload
// Rev 1.0
// ============================================================================
`default_nettype none

module umi_ingress_fifo2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         nreset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic [1:0]   count,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] r_mem [2];
    logic [W-1:0] r_hold;
    logic         r_wptr;
    logic         r_rptr;
    logic [1:0]   r_count;
    logic         w_push;
    logic         w_pop;

    assign full   = (r_count == 2'd2);
    assign empty  = (r_count == 2'd0);
    assign count  = r_count;
    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;

    // When empty, present the last popped entry instead of a stale slot
    assign dout = empty ? r_hold : r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_hold   <= '0;
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= din;
                r_wptr        <= ~r_wptr;
            end
            if (w_pop) begin
                r_hold <= r_mem[r_rptr];
                r_rptr <= ~r_rptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/umi_crossbar_ingress.sv
// ============================================================================
// umi_crossbar_ingress : per-input crossbar ingress, buffers and port-decodes
// Rev 1.0
// ============================================================================
`default_nettype none

module umi_crossbar_ingress #(
    parameter int DW      = 256,
    parameter int CW      = 32,
    parameter int AW      = 64,
    parameter int N       = 2,
    parameter int IDSB    = 40,
    parameter int DEFPORT = 0
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          err_clear,
    input  logic          umi_in_valid,
    input  logic [CW-1:0] umi_in_cmd,
    input  logic [AW-1:0] umi_in_dstaddr,
    input  logic [AW-1:0] umi_in_srcaddr,
    input  logic [DW-1:0] umi_in_data,
    output logic          umi_in_ready,
    output logic [N-1:0]  xbar_request,
    output logic [CW-1:0] xbar_cmd,
    output logic [AW-1:0] xbar_dstaddr,
    output logic [AW-1:0] xbar_srcaddr,
    output logic [DW-1:0] xbar_data,
    input  logic          xbar_ready,
    output logic [15:0]   err_count
);

    localparam int              PW        = $clog2(N);
    localparam int              W         = N + CW + 2*AW + DW;
    localparam logic [PW:0]     C_N       = (PW+1)'(N);
    localparam logic [PW-1:0]   C_DEFPORT = PW'(DEFPORT);

    logic [PW-1:0] w_idx;
    logic          w_oor;
    logic [PW-1:0] w_port;
    logic [N-1:0]  w_onehot;
    logic [N-1:0]  w_head_req;
    logic [W-1:0]  w_din;
    logic [W-1:0]  w_dout;
    logic [1:0]    w_count;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_ready_next;
    logic          r_ready;
    logic [15:0]   r_err_count;

    assign w_idx  = umi_in_dstaddr[IDSB +: PW];
    assign w_oor  = ({1'b0, w_idx} >= C_N);
    assign w_port = w_oor ? C_DEFPORT : w_idx;

    for (genvar g = 0; g < N; g++) begin : g_onehot
        assign w_onehot[g] = (w_port == PW'(g));
    end

    assign w_push = umi_in_valid & r_ready;
    assign w_pop  = (|xbar_request) & xbar_ready;
    assign w_din  = {w_onehot, umi_in_cmd, umi_in_dstaddr, umi_in_srcaddr, umi_in_data};

    umi_ingress_fifo2 #(
        .W (W)
    ) u_fifo (
        .clk    (clk),
        .nreset (nreset),
        .push   (w_push),
        .pop    (w_pop),
        .din    (w_din),
        .dout   (w_dout),
        .count  (w_count),
        .full   (w_full),
        .empty  (w_empty)
    );

    assign {w_head_req, xbar_cmd, xbar_dstaddr, xbar_srcaddr, xbar_data} = w_dout;
    assign xbar_request = w_empty ? '0 : w_head_req;

    // Ready is low next cycle exactly when the FIFO ends this cycle with 2 entries
    assign w_ready_next = ~((w_full & ~w_pop) |
                            ((w_count == 2'd1) & w_push & ~w_pop));

    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_ready     <= 1'b0;
            r_err_count <= 16'd0;
        end else begin
            r_ready <= w_ready_next;
            if (err_clear) begin
                r_err_count <= 16'd0;
            end else if (w_push && w_oor && (r_err_count != 16'hFFFF)) begin
                r_err_count <= r_err_count + 16'd1;
            end
        end
    end

    assign umi_in_ready = r_ready;
    assign err_count    = r_err_count;

endmodule

`default_nettype wire

// File: tb/tb_umi_crossbar_ingress.sv
// ============================================================================
// tb_umi_crossbar_ingress : directed bench, N=4 instance plus N=3/DEFPORT=1
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_umi_crossbar_ingress;

    localparam int DW = 256;
    localparam int CW = 32;
    localparam int AW = 64;

    logic clk;
    logic nreset;

    // Instance a: N=4, DEFPORT=0
    logic          a_err_clear, a_valid, a_ready, a_xready;
    logic [CW-1:0] a_cmd, a_xcmd;
    logic [AW-1:0] a_dst, a_src, a_xdst, a_xsrc;
    logic [DW-1:0] a_data, a_xdata;
    logic [3:0]    a_req;
    logic [15:0]   a_err;

    // Instance b: N=3, DEFPORT=1
    logic          b_err_clear, b_valid, b_ready, b_xready;
    logic [CW-1:0] b_cmd, b_xcmd;
    logic [AW-1:0] b_dst, b_src, b_xdst, b_xsrc;
    logic [DW-1:0] b_data, b_xdata;
    logic [2:0]    b_req;
    logic [15:0]   b_err;

    int total = 0;
    int bad   = 0;

    umi_crossbar_ingress #(.DW(DW), .CW(CW), .AW(AW), .N(4), .IDSB(40), .DEFPORT(0)) dut_a (
        .clk(clk), .nreset(nreset), .err_clear(a_err_clear),
        .umi_in_valid(a_valid), .umi_in_cmd(a_cmd), .umi_in_dstaddr(a_dst),
        .umi_in_srcaddr(a_src), .umi_in_data(a_data), .umi_in_ready(a_ready),
        .xbar_request(a_req), .xbar_cmd(a_xcmd), .xbar_dstaddr(a_xdst),
        .xbar_srcaddr(a_xsrc), .xbar_data(a_xdata), .xbar_ready(a_xready),
        .err_count(a_err)
    );

    umi_crossbar_ingress #(.DW(DW), .CW(CW), .AW(AW), .N(3), .IDSB(40), .DEFPORT(1)) dut_b (
        .clk(clk), .nreset(nreset), .err_clear(b_err_clear),
        .umi_in_valid(b_valid), .umi_in_cmd(b_cmd), .umi_in_dstaddr(b_dst),
        .umi_in_srcaddr(b_src), .umi_in_data(b_data), .umi_in_ready(b_ready),
        .xbar_request(b_req), .xbar_cmd(b_xcmd), .xbar_dstaddr(b_xdst),
        .xbar_srcaddr(b_xsrc), .xbar_data(b_xdata), .xbar_ready(b_xready),
        .err_count(b_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CW-1:0] pk_cmd(input int k);
        return 32'hA000_0000 | 32'(k);
    endfunction
    function automatic logic [AW-1:0] pk_dst(input int k, input logic [1:0] port);
        return 64'h0000_0000_1234_0000 | 64'(k) | ({62'd0, port} << 40);
    endfunction
    function automatic logic [AW-1:0] pk_src(input int k);
        return 64'h5500_0000_0000_0000 | 64'(k);
    endfunction
    function automatic logic [DW-1:0] pk_data(input int k);
        return {8{pk_cmd(k)}};
    endfunction

    task automatic drive_a(input int k, input logic [1:0] port);
        a_valid = 1'b1;
        a_cmd   = pk_cmd(k);
        a_dst   = pk_dst(k, port);
        a_src   = pk_src(k);
        a_data  = pk_data(k);
    endtask

    task automatic drive_b(input int k, input logic [1:0] port);
        b_valid = 1'b1;
        b_cmd   = pk_cmd(k);
        b_dst   = pk_dst(k, port);
        b_src   = pk_src(k);
        b_data  = pk_data(k);
    endtask

    logic [1:0] ports [100];

    initial begin
        nreset = 1'b0;
        a_err_clear = 1'b0; a_valid = 1'b0; a_xready = 1'b0;
        a_cmd = '0; a_dst = '0; a_src = '0; a_data = '0;
        b_err_clear = 1'b0; b_valid = 1'b0; b_xready = 1'b0;
        b_cmd = '0; b_dst = '0; b_src = '0; b_data = '0;

        // Reset state
        repeat (3) tick();
        check("rst_ready", a_ready, 0);
        check("rst_req", a_req, 0);
        check("rst_cmd", a_xcmd, 0);
        check("rst_data", a_xdata, 0);
        check("rst_err", a_err, 0);
        nreset = 1'b1;
        check("rel_ready_still_low", a_ready, 0);
        tick();
        check("rel_ready_high", a_ready, 1);
        check("rel_req_zero", a_req, 0);

        // Single packet to port 2, popped immediately
        a_xready = 1'b1;
        drive_a(1, 2'b10);
        tick();
        a_valid = 1'b0;
        check("p1_req", a_req, 4'b0100);
        check("p1_cmd", a_xcmd, pk_cmd(1));
        check("p1_dst", a_xdst, pk_dst(1, 2'b10));
        check("p1_src", a_xsrc, pk_src(1));
        check("p1_data", a_xdata, pk_data(1));
        tick();
        check("p1_req_gone", a_req, 0);
        check("p1_cmd_held", a_xcmd, pk_cmd(1));

        // Backpressure: A(3), B(1) accepted, C(2) held upstream
        a_xready = 1'b0;
        drive_a(10, 2'd3);
        tick();
        check("bp_a_req", a_req, 4'b1000);
        check("bp_ready_after_a", a_ready, 1);
        drive_a(11, 2'd1);
        tick();
        check("bp_ready_after_b", a_ready, 0);
        drive_a(12, 2'd2);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_hold_req", a_req, 4'b1000);
            check("bp_hold_cmd", a_xcmd, pk_cmd(10));
            check("bp_hold_ready", a_ready, 0);
        end
        a_xready = 1'b1;
        tick();
        check("bp_b_req", a_req, 4'b0010);
        check("bp_b_cmd", a_xcmd, pk_cmd(11));
        check("bp_ready_back", a_ready, 1);
        tick();
        a_valid = 1'b0;
        check("bp_c_req", a_req, 4'b0100);
        check("bp_c_cmd", a_xcmd, pk_cmd(12));
        tick();
        check("bp_drained", a_req, 0);

        // Streaming, one packet per cycle
        for (int k = 0; k < 100; k++) ports[k] = 2'($urandom_range(0, 3));
        for (int k = 0; k < 100; k++) begin
            drive_a(100 + k, ports[k]);
            tick();
            check("st_req", a_req, 4'b0001 << ports[k]);
            check("st_cmd", a_xcmd, pk_cmd(100 + k));
            check("st_ready", a_ready, 1);
        end
        a_valid = 1'b0;
        tick();
        check("st_drained", a_req, 0);

        // N=3 instance: out-of-range index goes to DEFPORT and counts
        check("b_ready", b_ready, 1);
        drive_b(200, 2'd3);
        tick();
        check("b_oor_req", b_req, 3'b010);
        check("b_oor_err", b_err, 1);
        drive_b(201, 2'd2);
        tick();
        b_valid = 1'b0;
        check("b_inrange_err", b_err, 1);
        check("b_head_stable", b_req, 3'b010);
        b_err_clear = 1'b1;
        tick();
        b_err_clear = 1'b0;
        check("b_err_cleared", b_err, 0);
        b_xready = 1'b1;
        tick();
        check("b_second_req", b_req, 3'b100);
        check("b_second_cmd", b_xcmd, pk_cmd(201));
        tick();
        check("b_drained", b_req, 0);
        drive_b(202, 2'd3);
        b_err_clear = 1'b1;
        tick();
        b_valid = 1'b0;
        b_err_clear = 1'b0;
        check("b_clear_priority", b_err, 0);
        check("b_oor2_req", b_req, 3'b010);
        tick();
        check("b_oor2_drained", b_req, 0);

        // Reset while full: old packets discarded
        a_xready = 1'b0;
        drive_a(300, 2'd1);
        tick();
        drive_a(301, 2'd2);
        tick();
        a_valid = 1'b0;
        check("mr_full_ready", a_ready, 0);
        check("mr_full_req", a_req, 4'b0010);
        nreset = 1'b0;
        tick();
        check("mr_rst_req", a_req, 0);
        check("mr_rst_ready", a_ready, 0);
        check("mr_rst_cmd", a_xcmd, 0);
        nreset = 1'b1;
        a_xready = 1'b1;
        tick();
        check("mr_rel_ready", a_ready, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("mr_no_old_req", a_req, 0);
            check("mr_no_old_cmd", a_xcmd, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/umi_crossbar_ingress.md
# umi_crossbar_ingress

Per-input ingress stage for the UMI NxN crossbar. It accepts one UMI request stream with a valid/ready handshake and buffers it in a 2-entry FIFO. It decodes each packet's dstaddr into a one-hot output-port request. It presents the packet to the crossbar and holds it until the crossbar's per-input ready completes the transfer. One instance sits in front of each crossbar input. Top level scatters each instance's N-bit request into crossbar request bits {i, i+N, i+2N, …}.

## Interface
Parameters:
- DW, 256, UMI data width
- CW, 32, UMI command width
- AW, 64, UMI address width
- N, 2, number of crossbar output ports (≥2)
- IDSB, 40, LSB of destination-port field in dstaddr; field width PW = $clog2(N)
- DEFPORT, 0, output port used when decoded index ≥ N

Ports (reset is synchronous and active-low; single clock):
- clk  input  1  clock
- nreset  input  1  synchronous active-low reset
- err_clear  input  1  synchronous clear of err_count
- umi_in_valid  input  1  upstream packet valid
- umi_in_cmd  input  CW  upstream command
- umi_in_dstaddr  input  AW  upstream destination address
- umi_in_srcaddr  input  AW  upstream source address
- umi_in_data  input  DW  upstream data
- umi_in_ready  output  1  registered ready to upstream
- xbar_request  output  N  one-hot port request to crossbar (this input's slice)
- xbar_cmd / xbar_dstaddr / xbar_srcaddr  output  CW/AW/AW  head-of-FIFO packet fields
- xbar_data  output  DW  head-of-FIFO data
- xbar_ready  input  1  crossbar umi_in_ready bit for this input
- err_count  output  16  saturating count of packets routed to DEFPORT due to out-of-range index

## Operation
- Push = umi_in_valid & umi_in_ready. Pop = (|xbar_request) & xbar_ready.
- FIFO: 2 entries, write pointer, read pointer, count 0..2. Simultaneous push and pop: count is unchanged, and both pointers advance (mod 2).
- Decode happens at push. idx = dstaddr[IDSB +: PW]. Stored port = idx if idx < N, else DEFPORT. Stored one-hot = 1 << port. Only the one-hot is stored with the packet; no re-decode at output.
- xbar_request = head one-hot when count > 0, else all zeros. xbar_* fields = head entry. Contents are don't-care when empty, but are held at the last popped value (no X).
- Request and fields stay stable while count > 0 and no pop occurs. No retraction.
- umi_in_ready is registered: next value = (count_next < 2). An upstream valid with ready low is ignored.
- err_count increments on each push with idx ≥ N. It saturates at 16'hFFFF. err_clear has priority over increment and sets the count to 0.
- Reset, mid-operation: all stored packets are discarded. No pop or push is accepted during the reset cycle.

## Timing
- Reset values: umi_in_ready=0, xbar_request=0, xbar_cmd/dstaddr/srcaddr/data=0, err_count=0, count=0, pointers=0.
- umi_in_ready rises to 1 in the first clk edge after nreset is sampled high.
- Latency: a packet pushed at edge t is on xbar_request/xbar_* after edge t (one cycle). There is no combinational path from umi_in_* to xbar_*.
- There is no combinational path from xbar_ready to umi_in_ready.
- Throughput: 1 packet/cycle sustained while xbar_ready=1 continuously.
- Full: count=2 → umi_in_ready=0 on the following cycle. A pop in that cycle re-asserts ready one cycle later.
- Empty with push: the request appears the next cycle, and a pop may occur in that same cycle.

## Structure
- No new shared package. UMI width defaults stay as module parameters consistent with the crossbar. PW is a localparam.
- One sub-module, umi_ingress_fifo2. It is a generic 2-entry, W-bit synchronous FIFO with push/pop/count/full/empty, parameterized by W. The payload W = N+CW+2*AW+DW. Decode and error counter live in the parent.

## Test plan
- Reset release, N=4, IDSB=40: umi_in_ready=0 during reset and 1 one cycle after nreset high. xbar_request=4'b0000.
- Push dstaddr[41:40]=2'b10, xbar_ready=1: next cycle xbar_request=4'b0100 with matching cmd/addr/data. Popped that cycle, so the request returns to 0 after.
- N=3, IDSB=40, dstaddr[41:40]=2'b11, DEFPORT=1: xbar_request=3'b010 and err_count=1. Then err_clear=1 → err_count=0.
- xbar_ready=0, push 3 back-to-back packets A,B,C: A and B accepted. umi_in_ready=0 after the 2nd push, and C is held upstream. Request stays at A's port unchanged for 10 cycles. Raise xbar_ready: A, B, C delivered in order.
- Streaming 100 packets with random ports, xbar_ready=1: one packet per cycle, order preserved, no drops.
- Assert nreset low with count=2: after release xbar_request=0, umi_in_ready returns to 1, and the old packets never appear.
